crossbar_arb: RTL and testbench

- Parametrised successor to the fixed 16-master crossbar controller. Arbitrates N_MASTERS request lines onto one shared crossbar datapath.
- Fair round-robin selection replaces the fixed scheme.
- Exclusive ownership is held from grant until an explicit release. Binary owner ID is exported for the datapath mux.
- Emits set_owner/clr_owner pulses to the datapath, same roles as the existing crossbar_dp.

---
 rtl/crossbar_arb.sv | 151 +++++++++++++++
 tb/tb_crossbar_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arb.sv
// ---------------------------------------------------------------------------
// crossbar_arb : round-robin owner arbiter for a shared crossbar datapath
// Optional forced revoke after MAX_HOLD cycles: define CROSSBAR_ARB_TIMEOUT_EN
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crossbar_arb #(
  parameter int N_MASTERS = 16,
  parameter int IDW       = $clog2(N_MASTERS),
  parameter int MAX_HOLD  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] request,
  input  logic [N_MASTERS-1:0] release_req,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDW-1:0]       owner_id,
  output logic                 owner_valid,
  output logic                 set_owner,
  output logic                 clr_owner,
  output logic                 timeout
);

  if (N_MASTERS < 2 || N_MASTERS > 64) begin : g_bad_n_masters
    $error("crossbar_arb: N_MASTERS out of range");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("crossbar_arb: MAX_HOLD out of range");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       rr_ptr, rr_nxt;
  logic [N_MASTERS-1:0] grant_nxt;
  logic [IDW-1:0]       owner_id_nxt;
  logic                 owner_valid_nxt;
  logic                 set_nxt;
  logic                 clr_nxt;
  logic                 pick_valid;
  logic [IDW-1:0]       pick_id;
  logic [IDW-1:0]       cand_id;
  int                   cand;
  logic                 release_hit;
  logic                 limit;

  // Scan downward so the last hit wins: that is the first requester at or above rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = 0;
    cand_id    = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      cand_id = IDW'(cand);
      if (request[cand_id]) begin
        pick_valid = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  assign release_hit = release_req[owner_id];

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt, hold_nxt;
  logic        to_nxt;

  assign limit  = (hold_cnt == 16'(MAX_HOLD - 1));
  assign to_nxt = (state == BUSY) && limit && !release_hit;

  always_comb begin
    hold_nxt = hold_cnt;
    if (state == IDLE) hold_nxt = '0;
    else               hold_nxt = hold_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      timeout  <= to_nxt;
    end
  end
`else
  assign limit   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    rr_nxt          = rr_ptr;
    grant_nxt       = grant;
    owner_id_nxt    = owner_id;
    owner_valid_nxt = owner_valid;
    set_nxt         = 1'b0;
    clr_nxt         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt          = BUSY;
          grant_nxt          = '0;
          grant_nxt[pick_id] = 1'b1;
          owner_id_nxt       = pick_id;
          owner_valid_nxt    = 1'b1;
          set_nxt            = 1'b1;
        end
      end
      BUSY: begin
        if (release_hit || limit) begin
          state_nxt       = IDLE;
          grant_nxt       = '0;
          owner_valid_nxt = 1'b0;
          clr_nxt         = 1'b1;
          rr_nxt          = (owner_id == IDW'(N_MASTERS - 1)) ? '0 : owner_id + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      set_owner   <= 1'b0;
      clr_owner   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      grant       <= grant_nxt;
      owner_id    <= owner_id_nxt;
      owner_valid <= owner_valid_nxt;
      set_owner   <= set_nxt;
      clr_owner   <= clr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crossbar_arb.sv
// ---------------------------------------------------------------------------
// tb_crossbar_arb : vectors, corner sequences and random run vs. a queue-free model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_crossbar_arb;

  localparam int MH = 8;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req16 = '0, rel16 = '0, g16;
  logic [3:0]  id16;
  logic        v16, s16, c16, t16;
  logic [4:0]  req5 = '0, rel5 = '0, g5;
  logic [2:0]  id5;
  logic        v5, s5, c5, t5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_arb #(.N_MASTERS(16), .MAX_HOLD(MH)) u16 (
    .clk(clk), .rst_n(rst_n), .request(req16), .release_req(rel16),
    .grant(g16), .owner_id(id16), .owner_valid(v16),
    .set_owner(s16), .clr_owner(c16), .timeout(t16));

  crossbar_arb #(.N_MASTERS(5), .MAX_HOLD(MH)) u5 (
    .clk(clk), .rst_n(rst_n), .request(req5), .release_req(rel5),
    .grant(g5), .owner_id(id5), .owner_valid(v5),
    .set_owner(s5), .clr_owner(c5), .timeout(t5));

  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int hold;
    bit set;
    bit clr;
    bit to;
  } model_t;

  model_t m16, m5;

  function automatic model_t model_init();
    model_t r;
    r.busy = 0; r.owner = 0; r.ptr = 0; r.hold = 0;
    r.set = 0; r.clr = 0; r.to = 0;
    return r;
  endfunction

  // One clock of the arbitration rules, in plain integer arithmetic.
  function automatic model_t step(model_t m, int n, logic [15:0] req, logic [15:0] rel);
    model_t r;
    bit     done, rel_ok, lim;
    int     c;
    r = m; done = 0;
    r.set = 0; r.clr = 0; r.to = 0;
    if (!m.busy) begin
      for (int k = 0; k < n; k++) begin
        c = (m.ptr + k) % n;
        if (!done && req[c]) begin
          done = 1; r.busy = 1; r.owner = c; r.hold = 0; r.set = 1;
        end
      end
    end else begin
      rel_ok = rel[m.owner];
      lim    = TO_EN && (m.hold == MH - 1);
      if (rel_ok || lim) begin
        r.busy = 0; r.clr = 1; r.to = lim && !rel_ok;
        r.ptr  = (m.owner + 1) % n;
      end else begin
        r.hold = m.hold + 1;
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(string nm, model_t m, logic [63:0] g, logic [63:0] id,
                           logic v, logic s, logic c, logic t);
    check({nm, ".grant"},    g,  m.busy ? (64'd1 << m.owner) : 64'd0);
    check({nm, ".owner_id"}, id, 64'(m.owner));
    check({nm, ".valid"},    64'(v), 64'(m.busy));
    check({nm, ".set"},      64'(s), 64'(m.set));
    check({nm, ".clr"},      64'(c), 64'(m.clr));
    check({nm, ".timeout"},  64'(t), 64'(m.to));
  endtask

  task automatic tick(logic [15:0] r16, logic [15:0] l16, logic [4:0] r5, logic [4:0] l5);
    req16 = r16; rel16 = l16; req5 = r5; rel5 = l5;
    @(posedge clk);
    #1;
    m16 = step(m16, 16, r16, l16);
    m5  = step(m5, 5, {11'd0, r5}, {11'd0, l5});
    cmp_model("u16", m16, 64'(g16), 64'(id16), v16, s16, c16, t16);
    cmp_model("u5",  m5,  64'(g5),  64'(id5),  v5,  s5,  c5,  t5);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req16 = '0; rel16 = '0; req5 = '0; rel5 = '0;
    m16 = model_init();
    m5  = model_init();
    repeat (2) @(posedge clk);
    #1;
    check("rst.outputs16", {g16, id16, v16, s16, c16, t16}, '0);
    check("rst.outputs5",  {g5, id5, v5, s5, c5, t5}, '0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic [15:0] rel;
    logic [15:0] grant;
    logic [3:0]  id;
    logic        valid;
    logic        set;
    logic        clr;
  } vec_t;

  vec_t vecs[10];
  int   cnt;
  bit   seen_to;

  initial begin
    vecs[0] = '{16'h0010, 16'h0000, 16'h0010, 4'd4, 1, 1, 0};
    vecs[1] = '{16'h0010, 16'h0000, 16'h0010, 4'd4, 1, 0, 0};
    vecs[2] = '{16'h0110, 16'h0000, 16'h0010, 4'd4, 1, 0, 0};
    vecs[3] = '{16'h0110, 16'h0010, 16'h0000, 4'd4, 0, 0, 1};
    vecs[4] = '{16'h0110, 16'h0000, 16'h0100, 4'd8, 1, 1, 0};
    vecs[5] = '{16'h0110, 16'h0001, 16'h0100, 4'd8, 1, 0, 0};
    vecs[6] = '{16'h0000, 16'h0100, 16'h0000, 4'd8, 0, 0, 1};
    vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 4'd8, 0, 0, 0};
    vecs[8] = '{16'h0000, 16'h0010, 16'h0000, 4'd8, 0, 0, 0};
    vecs[9] = '{16'h0001, 16'h0000, 16'h0001, 4'd0, 1, 1, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].req, vecs[i].rel, 5'd0, 5'd0);
      check($sformatf("vec%0d.grant", i), 64'(g16), 64'(vecs[i].grant));
      check($sformatf("vec%0d.id", i),    64'(id16), 64'(vecs[i].id));
      check($sformatf("vec%0d.vsc", i),   64'({v16, s16, c16}),
            64'({vecs[i].valid, vecs[i].set, vecs[i].clr}));
    end

    // Full rotation with everyone requesting: 0,1,...,15,0.
    do_reset();
    for (int g = 0; g < 17; g++) begin
      tick(16'hFFFF, 16'h0000, 5'd0, 5'd0);
      check($sformatf("rr_order%0d", g), 64'({s16, id16}), 64'({1'b1, 4'(g % 16)}));
      tick(16'hFFFF, 16'h0000, 5'd0, 5'd0);
      tick(16'hFFFF, 16'h0000, 5'd0, 5'd0);
      tick(16'hFFFF, 16'd1 << (g % 16), 5'd0, 5'd0);
      check($sformatf("rr_clr%0d", g), 64'({g16, c16}), 64'({16'h0000, 1'b1}));
    end

    // Non-owner release ignored, then asynchronous reset mid-ownership.
    do_reset();
    tick(16'h0020, 16'h0000, 5'd0, 5'd0);
    tick(16'h0020, 16'h0001, 5'd0, 5'd0);
    check("nonowner_rel.grant", 64'(g16), 64'h0020);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.outputs", {g16, id16, v16, s16, c16, t16}, '0);
    do_reset();
    tick(16'hFFFF, 16'h0000, 5'd0, 5'd0);
    check("after_rst.owner0", 64'({g16, id16}), 64'({16'h0001, 4'd0}));

    // Five masters: pointer wraps from 4 to 0.
    do_reset();
    tick(16'h0, 16'h0, 5'b10000, 5'b00000);
    tick(16'h0, 16'h0, 5'b10001, 5'b10000);
    tick(16'h0, 16'h0, 5'b10001, 5'b00000);
    check("n5_wrap", 64'({g5, id5}), 64'({5'b00001, 3'd0}));

    // Owner that never releases.
    do_reset();
    cnt = 0;
    seen_to = 0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    tick(16'h0004, 16'h0, 5'd0, 5'd0);
    while (g16 != 16'h0 && cnt < 50) begin
      cnt++;
      tick(16'h0004, 16'h0, 5'd0, 5'd0);
    end
    check("to.hold_cycles", 64'(cnt), 64'(MH));
    check("to.pulses", 64'({t16, c16}), 64'({1'b1, 1'b1}));
`else
    tick(16'h0004, 16'h0, 5'd0, 5'd0);
    for (int i = 0; i < 1100; i++) begin
      tick(16'h0004, 16'h0, 5'd0, 5'd0);
      if (g16 == 16'h0004) cnt++;
      if (t16) seen_to = 1;
    end
    check("noto.hold_cycles", 64'(cnt), 64'd1100);
    check("noto.timeout_seen", 64'(seen_to), 64'd0);
`endif

    // Random traffic on both instances against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r16, l16;
      logic [4:0]  r5, l5;
      r16 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
      l16 = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
      r5  = 5'($urandom);
      l5  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'h0;
      tick(r16, l16, r5, l5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
